hqm_mem_rst_seq: RTL

//  Sequences reset release and init for NUM_BANKS memory banks in one clock domain.
//  - Staggers the release of each bank_rst_n, then runs a concurrent req/done init handshake per bank.
//  - Raises mem_ready once every bank has completed init.
//  - Sits downstream of the domain reset synchronizer and honours the scan reset-bypass controls.

---
 rtl/hqm_mem_rst_seq_pkg.sv | 16 +
 rtl/hqm_mem_rst_seq_bank.sv | 54 +++++
 rtl/hqm_mem_rst_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hqm_mem_rst_seq_pkg.sv
// Shared types and constants for the memory reset/init sequencer.
// Optional INIT watchdog is enabled with HQM_MEM_RST_SEQ_TIMEOUT_EN.
package hqm_mem_rst_seq_pkg;

    typedef enum logic [1:0] {HOLD, RELEASE, INIT, DONE} hqm_mem_rst_seq_state_t;

    localparam int HQM_MEM_RST_SEQ_MAX_BANKS = 16;
    localparam int HQM_MEM_RST_SEQ_IDX_W     = $clog2(HQM_MEM_RST_SEQ_MAX_BANKS);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hqm_mem_rst_seq_bank.sv
// Per-bank init request / done-seen flop pair with the req/done handshake.
// Watchdog abort is driven by the top only when HQM_MEM_RST_SEQ_TIMEOUT_EN is defined.
module hqm_mem_rst_seq_bank
    import hqm_mem_rst_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    input  logic clr_i,
    input  logic init_done_i,
    output logic init_req_o,
    output logic done_seen_o,
    output logic done_hit_o
);

    logic req_q, req_d;
    logic seen_q, seen_d;

    // init_done only counts while this bank is actually requesting
    assign done_hit_o = req_q & init_done_i;

    always_comb begin
        req_d  = req_q;
        seen_d = seen_q;
        if (clr_i) begin
            req_d  = 1'b0;
            seen_d = 1'b0;
        end else begin
            if (start_i) begin
                req_d = 1'b1;
            end else if (done_hit_o || abort_i) begin
                req_d = 1'b0;
            end
            if (done_hit_o) begin
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            req_q  <= req_d;
            seen_q <= seen_d;
        end
    end

    assign init_req_o  = req_q;
    assign done_seen_o = seen_q;

endmodule

// File: rtl/hqm_mem_rst_seq.sv
// Staggered bank reset release followed by a concurrent per-bank init handshake.
// Define HQM_MEM_RST_SEQ_TIMEOUT_EN to enable the sticky INIT watchdog (timeout_err).
module hqm_mem_rst_seq
    import hqm_mem_rst_seq_pkg::*;
#(
    parameter int NUM_BANKS      = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fscan_rstbypen,
    input  logic                 fscan_byprst_b,
    input  logic                 reinit_req,
    input  logic [NUM_BANKS-1:0] init_done,
    output logic [NUM_BANKS-1:0] bank_rst_n,
    output logic [NUM_BANKS-1:0] init_req,
    output logic                 mem_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int IDX_W = HQM_MEM_RST_SEQ_IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);

    hqm_mem_rst_seq_state_t state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_nxt;
    logic [NUM_BANKS-1:0]   bank_rst_n_q;
    logic                   mem_ready_q;
    logic                   busy_q;

    logic [NUM_BANKS-1:0] req;
    logic [NUM_BANKS-1:0] seen;
    logic [NUM_BANKS-1:0] hit;
    logic                 start;
    logic                 abort;
    logic                 clr;
    logic                 all_done;

    // Banks completing this very cycle count, so mem_ready rises one cycle after the last done
    assign all_done = &(seen | hit);
    assign idx_nxt  = idx_q + 1'b1;
    assign start    = ~fscan_rstbypen & (state_q == RELEASE) & (cnt_q == '0) & (idx_q == LAST_IDX);
    assign clr      = fscan_rstbypen | ((state_q == DONE) & reinit_req);

`ifdef HQM_MEM_RST_SEQ_TIMEOUT_EN
    logic timeout_err_q;
    assign abort = ~fscan_rstbypen & (state_q == INIT) & ~all_done & (cnt_q == '0);
`else
    assign abort = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        hqm_mem_rst_seq_bank u_bank (
            .clk         (clk),
            .rst         (rst),
            .start_i     (start),
            .abort_i     (abort),
            .clr_i       (clr),
            .init_done_i (init_done[b]),
            .init_req_o  (req[b]),
            .done_seen_o (seen[b]),
            .done_hit_o  (hit[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            bank_rst_n_q <= '0;
            mem_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
`ifdef HQM_MEM_RST_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else if (fscan_rstbypen) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            bank_rst_n_q <= '0;
            mem_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                // HOLD climbs from the cleared value so reset/bypass/reinit all restart at cycle 0
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
                        state_q         <= RELEASE;
                        cnt_q           <= CNT_W'(GAP_CYCLES - 1);
                        idx_q           <= '0;
                        bank_rst_n_q[0] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= INIT;
`ifdef HQM_MEM_RST_SEQ_TIMEOUT_EN
                        cnt_q   <= CNT_W'(TIMEOUT_CYCLES - 1);
`else
                        cnt_q   <= '0;
`endif
                    end else begin
                        idx_q <= idx_nxt;
                        cnt_q <= CNT_W'(GAP_CYCLES - 1);
                        for (int k = 0; k < NUM_BANKS; k++) begin
                            if (idx_nxt == IDX_W'(k)) begin
                                bank_rst_n_q[k] <= 1'b1;
                            end
                        end
                    end
                end
                INIT: begin
                    if (all_done) begin
                        state_q     <= DONE;
                        mem_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
`ifdef HQM_MEM_RST_SEQ_TIMEOUT_EN
                    end else if (cnt_q == '0) begin
                        state_q       <= DONE;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (reinit_req) begin
                        state_q      <= HOLD;
                        cnt_q        <= '0;
                        idx_q        <= '0;
                        bank_rst_n_q <= '0;
                        mem_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
`ifdef HQM_MEM_RST_SEQ_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    // Scan bypass overrides the flopped values combinationally
    assign bank_rst_n = fscan_rstbypen ? {NUM_BANKS{fscan_byprst_b}} : bank_rst_n_q;
    assign init_req   = fscan_rstbypen ? '0 : req;
    assign mem_ready  = mem_ready_q & ~fscan_rstbypen;
    assign busy       = busy_q;
`ifdef HQM_MEM_RST_SEQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
